counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl.sv | 169 ++++++++++++++++
 tb/tb_counter_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// Two-requester round-robin load/run controller for an external counter.
// Optional COUNTER_CTRL_MATCH_EN adds a compare input and a DONE state with a one-cycle out_match pulse.
module counter_ctrl #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  logic       in_req_a,
  input  logic       in_req_b,
  input  logic [7:0] in_value_a,
  input  logic [7:0] in_value_b,
`ifdef COUNTER_CTRL_MATCH_EN
  input  logic [7:0] in_counter_value,
  input  logic [7:0] in_match_value,
  output logic       out_match,
`endif
  output logic [1:0] out_grant,
  output logic [7:0] out_load_value,
  output logic       out_load_now,
  output logic       out_write_now,
  output logic       out_busy
);

`ifdef COUNTER_CTRL_MATCH_EN
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;
`endif

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES);

  state_t     r_state;
  logic [3:0] r_hold_cnt;
  logic       r_prio_b;   // 1 = B wins a tie, 0 = A wins a tie
  logic [1:0] r_grant;
  logic [7:0] r_load_value;
  logic       r_load_now;
  logic       r_write_now;
  logic       r_busy;

  state_t     w_state_next;
  logic [3:0] w_hold_next;
  logic       w_prio_b_next;
  logic [1:0] w_grant_next;
  logic [7:0] w_load_value_next;
  logic       w_load_now_next;
  logic       w_write_now_next;
  logic       w_busy_next;
  logic       w_owner_req;
  logic       w_pick_b;
`ifdef COUNTER_CTRL_MATCH_EN
  logic       r_match;
  logic       w_match_next;
`endif

  assign w_owner_req = (r_grant[0] & in_req_a) | (r_grant[1] & in_req_b);
  assign w_pick_b    = in_req_b & (~in_req_a | r_prio_b);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state      <= ST_IDLE;
      r_hold_cnt   <= 4'd0;
      r_prio_b     <= 1'b0;
      r_grant      <= 2'b00;
      r_load_value <= 8'h00;
      r_load_now   <= 1'b0;
      r_write_now  <= 1'b0;
      r_busy       <= 1'b0;
`ifdef COUNTER_CTRL_MATCH_EN
      r_match      <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_hold_cnt   <= w_hold_next;
      r_prio_b     <= w_prio_b_next;
      r_grant      <= w_grant_next;
      r_load_value <= w_load_value_next;
      r_load_now   <= w_load_now_next;
      r_write_now  <= w_write_now_next;
      r_busy       <= w_busy_next;
`ifdef COUNTER_CTRL_MATCH_EN
      r_match      <= w_match_next;
`endif
    end
  end

  // Outputs are computed for the next state so every output leaves a flop.
  always_comb begin
    w_state_next      = r_state;
    w_hold_next       = r_hold_cnt;
    w_prio_b_next     = r_prio_b;
    w_grant_next      = r_grant;
    w_load_value_next = r_load_value;
    w_load_now_next   = 1'b0;
    w_write_now_next  = 1'b0;
`ifdef COUNTER_CTRL_MATCH_EN
    w_match_next      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        w_grant_next = 2'b00;
        w_hold_next  = 4'd0;
        if (in_req_a | in_req_b) begin
          w_state_next      = ST_LOAD;
          w_grant_next      = w_pick_b ? 2'b10 : 2'b01;
          w_load_value_next = w_pick_b ? in_value_b : in_value_a;
          w_prio_b_next     = ~w_pick_b;
          w_hold_next       = 4'd1;
          w_load_now_next   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!w_owner_req) begin
          w_state_next = ST_IDLE;
          w_grant_next = 2'b00;
          w_hold_next  = 4'd0;
        end else if (r_hold_cnt >= HOLD_LAST) begin
          w_state_next     = ST_RUN;
          w_hold_next      = 4'd0;
          w_write_now_next = 1'b1;
        end else begin
          w_hold_next     = r_hold_cnt + 4'd1;
          w_load_now_next = 1'b1;
        end
      end
      ST_RUN: begin
`ifdef COUNTER_CTRL_MATCH_EN
        w_match_next = (in_counter_value == in_match_value);
`endif
        if (!w_owner_req) begin
          w_state_next = ST_IDLE;
          w_grant_next = 2'b00;
        end
`ifdef COUNTER_CTRL_MATCH_EN
        else if (w_match_next) begin
          w_state_next = ST_DONE;
        end
`endif
        else begin
          w_write_now_next = 1'b1;
        end
      end
`ifdef COUNTER_CTRL_MATCH_EN
      ST_DONE: begin
        if (!w_owner_req) begin
          w_state_next = ST_IDLE;
          w_grant_next = 2'b00;
        end
      end
`endif
      default: begin
        w_state_next = ST_IDLE;
        w_grant_next = 2'b00;
        w_hold_next  = 4'd0;
      end
    endcase
    w_busy_next = (w_state_next != ST_IDLE);
  end

  assign out_grant      = r_grant;
  assign out_load_value = r_load_value;
  assign out_load_now   = r_load_now;
  assign out_write_now  = r_write_now;
  assign out_busy       = r_busy;
`ifdef COUNTER_CTRL_MATCH_EN
  assign out_match      = r_match;
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed testbench for counter_ctrl; the match scenario is built only when COUNTER_CTRL_MATCH_EN is defined.
`timescale 1ns/1ps
module tb_counter_ctrl;

  logic       in_clk = 1'b0;
  logic       in_rst_n = 1'b0;
  logic       in_req_a = 1'b0;
  logic       in_req_b = 1'b0;
  logic [7:0] in_value_a = 8'h00;
  logic [7:0] in_value_b = 8'h00;
  logic [1:0] out_grant;
  logic [7:0] out_load_value;
  logic       out_load_now;
  logic       out_write_now;
  logic       out_busy;
  int         n_tests = 0;
  int         n_fail = 0;

`ifdef COUNTER_CTRL_MATCH_EN
  logic [7:0] in_counter_value;
  logic [7:0] in_match_value = 8'h05;
  logic       out_match;
  logic [7:0] model_cnt = 8'h00;

  always @(posedge in_clk) begin
    if (out_load_now) model_cnt <= out_load_value;
    else if (out_write_now) model_cnt <= model_cnt + 8'd1;
  end
  assign in_counter_value = model_cnt;
`endif

  counter_ctrl #(.HOLD_CYCLES(2)) dut (
    .in_clk(in_clk),
    .in_rst_n(in_rst_n),
    .in_req_a(in_req_a),
    .in_req_b(in_req_b),
    .in_value_a(in_value_a),
    .in_value_b(in_value_b),
`ifdef COUNTER_CTRL_MATCH_EN
    .in_counter_value(in_counter_value),
    .in_match_value(in_match_value),
    .out_match(out_match),
`endif
    .out_grant(out_grant),
    .out_load_value(out_load_value),
    .out_load_now(out_load_now),
    .out_write_now(out_write_now),
    .out_busy(out_busy)
  );

  always #5 in_clk = ~in_clk;

  task automatic tick;
    @(posedge in_clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    n_tests++; if ({out_grant, out_load_now, out_write_now, out_busy} !== 5'b0) begin n_fail++; $display("FAIL reset_outputs got=%b want=00000", {out_grant, out_load_now, out_write_now, out_busy}); end
    n_tests++; if (out_load_value !== 8'h00) begin n_fail++; $display("FAIL reset_load_value got=%h want=00", out_load_value); end
    @(negedge in_clk);
    in_rst_n = 1'b1;
    tick();
    n_tests++; if (out_busy !== 1'b0 || out_grant !== 2'b00) begin n_fail++; $display("FAIL idle_no_req busy=%b grant=%b want 0/00", out_busy, out_grant); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic;
    in_req_a = 1'b1; in_value_a = 8'h3C;
    tick();
    n_tests++; if (out_grant !== 2'b01) begin n_fail++; $display("FAIL basic_grant got=%b want=01", out_grant); end
    n_tests++; if (out_load_value !== 8'h3C) begin n_fail++; $display("FAIL basic_value got=%h want=3c", out_load_value); end
    n_tests++; if ({out_load_now, out_write_now, out_busy} !== 3'b101) begin n_fail++; $display("FAIL basic_load1 got=%b want=101", {out_load_now, out_write_now, out_busy}); end
    tick();
    n_tests++; if ({out_load_now, out_write_now} !== 2'b10) begin n_fail++; $display("FAIL basic_load2 got=%b want=10", {out_load_now, out_write_now}); end
    tick();
    n_tests++; if ({out_load_now, out_write_now} !== 2'b01) begin n_fail++; $display("FAIL basic_run1 got=%b want=01", {out_load_now, out_write_now}); end
    tick();
    n_tests++; if ({out_load_now, out_write_now, out_grant} !== 4'b0101) begin n_fail++; $display("FAIL basic_run2 got=%b want=0101", {out_load_now, out_write_now, out_grant}); end
    in_req_a = 1'b0;
    tick();
    n_tests++; if ({out_grant, out_load_now, out_write_now, out_busy} !== 5'b0) begin n_fail++; $display("FAIL basic_release got=%b want=00000", {out_grant, out_load_now, out_write_now, out_busy}); end
    $display("[TB] test_basic done");
  endtask

  task automatic test_arbitration;
    in_rst_n = 1'b0; #1; in_rst_n = 1'b1;
    in_req_a = 1'b1; in_req_b = 1'b1; in_value_a = 8'hA1; in_value_b = 8'hB2;
    tick();
    n_tests++; if (out_grant !== 2'b01 || out_load_value !== 8'hA1) begin n_fail++; $display("FAIL arb_first grant=%b val=%h want 01/a1", out_grant, out_load_value); end
    tick(); tick();
    n_tests++; if (out_write_now !== 1'b1 || out_grant !== 2'b01) begin n_fail++; $display("FAIL arb_a_run write=%b grant=%b want 1/01", out_write_now, out_grant); end
    in_req_a = 1'b0;
    tick();
    n_tests++; if (out_grant !== 2'b00 || out_busy !== 1'b0) begin n_fail++; $display("FAIL arb_idle_gap grant=%b busy=%b want 00/0", out_grant, out_busy); end
    tick();
    n_tests++; if (out_grant !== 2'b10 || out_load_value !== 8'hB2 || out_load_now !== 1'b1) begin n_fail++; $display("FAIL arb_b_grant grant=%b val=%h load=%b want 10/b2/1", out_grant, out_load_value, out_load_now); end
    in_req_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (out_grant !== 2'b10) begin n_fail++; $display("FAIL arb_no_preempt cyc=%0d grant=%b want=10", i, out_grant); end
    end
    in_req_b = 1'b0;
    tick();
    n_tests++; if (out_grant !== 2'b00) begin n_fail++; $display("FAIL arb_b_release grant=%b want=00", out_grant); end
    tick();
    n_tests++; if (out_grant !== 2'b01) begin n_fail++; $display("FAIL arb_a_again grant=%b want=01", out_grant); end
    in_req_a = 1'b0;
    tick();
    $display("[TB] test_arbitration done");
  endtask

  task automatic test_abort;
    in_req_b = 1'b1; in_value_b = 8'h77;
    tick();
    n_tests++; if (out_grant !== 2'b10 || out_load_now !== 1'b1) begin n_fail++; $display("FAIL abort_grant grant=%b load=%b want 10/1", out_grant, out_load_now); end
    in_req_b = 1'b0;
    tick();
    n_tests++; if ({out_grant, out_load_now, out_write_now, out_busy} !== 5'b0) begin n_fail++; $display("FAIL abort_idle got=%b want=00000", {out_grant, out_load_now, out_write_now, out_busy}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (out_write_now !== 1'b0 || out_grant !== 2'b00) begin n_fail++; $display("FAIL abort_no_run cyc=%0d write=%b grant=%b want 0/00", i, out_write_now, out_grant); end
    end
    $display("[TB] test_abort done");
  endtask

  task automatic test_async_reset;
    in_req_a = 1'b1; in_value_a = 8'h5A;
    tick(); tick(); tick();
    n_tests++; if (out_write_now !== 1'b1) begin n_fail++; $display("FAIL areset_pre_run write=%b want=1", out_write_now); end
    #2;
    in_req_b = 1'b1;
    in_rst_n = 1'b0;
    #1;
    n_tests++; if ({out_grant, out_load_now, out_write_now, out_busy} !== 5'b0) begin n_fail++; $display("FAIL areset_immediate got=%b want=00000", {out_grant, out_load_now, out_write_now, out_busy}); end
    #1;
    in_rst_n = 1'b1;
    tick();
    n_tests++; if (out_grant !== 2'b01) begin n_fail++; $display("FAIL areset_a_favoured grant=%b want=01", out_grant); end
    in_req_a = 1'b0; in_req_b = 1'b0;
    tick();
    $display("[TB] test_async_reset done");
  endtask

  task automatic test_value_hold;
    tick();
    in_req_a = 1'b1; in_value_a = 8'h11;
    tick();
    n_tests++; if (out_load_value !== 8'h11) begin n_fail++; $display("FAIL hold_latch val=%h want=11", out_load_value); end
    in_value_a = 8'h22;
    tick();
    n_tests++; if (out_load_value !== 8'h11 || out_load_now !== 1'b1) begin n_fail++; $display("FAIL hold_load val=%h load=%b want 11/1", out_load_value, out_load_now); end
    tick();
    n_tests++; if (out_load_value !== 8'h11 || out_write_now !== 1'b1) begin n_fail++; $display("FAIL hold_run val=%h write=%b want 11/1", out_load_value, out_write_now); end
    in_req_a = 1'b0;
    tick(); tick();
    $display("[TB] test_value_hold done");
  endtask

`ifdef COUNTER_CTRL_MATCH_EN
  task automatic test_match;
    int pulses;
    pulses = 0;
    in_req_a = 1'b1; in_value_a = 8'h00;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_match === 1'b1) pulses++;
    end
    n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL match_pulses got=%0d want=1", pulses); end
    n_tests++; if (out_write_now !== 1'b0 || out_grant !== 2'b01 || out_busy !== 1'b1) begin n_fail++; $display("FAIL match_done write=%b grant=%b busy=%b want 0/01/1", out_write_now, out_grant, out_busy); end
    n_tests++; if (model_cnt !== 8'h06) begin n_fail++; $display("FAIL match_count got=%h want=06", model_cnt); end
    in_req_a = 1'b0;
    tick();
    n_tests++; if ({out_grant, out_busy, out_match} !== 4'b0) begin n_fail++; $display("FAIL match_release got=%b want=0000", {out_grant, out_busy, out_match}); end
    $display("[TB] test_match done");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_arbitration();
    test_abort();
    test_async_reset();
    test_value_hold();
`ifdef COUNTER_CTRL_MATCH_EN
    test_match();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
